// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - IF/DM requester, response and memory signals of the port arbiter
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_flush;
    logic              if_rvalid;
    logic [31:0]       if_rdata;
    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_rvalid;
    logic [DATA_W-1:0] dm_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              stall_if;
    logic              stall_mem;

    modport slave (
        input  if_req, if_addr, if_flush, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output if_rvalid, if_rdata, dm_rvalid, dm_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, stall_if, stall_mem
    );

    modport master (
        output if_req, if_addr, if_flush, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  if_rvalid, if_rdata, dm_rvalid, dm_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, stall_if, stall_mem
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory arbiter between instruction fetch and data memory
module mem_port_arbiter #(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                reset,
    mem_port_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_DM} owner_t;

    localparam logic [3:0] LAT  = 4'(MEM_LAT);
    localparam logic [3:0] SMAX = 4'(STARVE_MAX);

    state_t            state_q, state_d;
    owner_t            owner_q, owner_d;
    logic [3:0]        lat_q, lat_d;
    logic [3:0]        starve_q, starve_d;
    logic              we_q, we_d;
    logic              cancel_q, cancel_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic              mem_en, mem_we, if_rvalid, dm_rvalid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            owner_q  <= OWN_NONE;
            lat_q    <= '0;
            starve_q <= '0;
            we_q     <= 1'b0;
            cancel_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            lat_q    <= lat_d;
            starve_q <= starve_d;
            we_q     <= we_d;
            cancel_q <= cancel_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        lat_d     = lat_q;
        starve_d  = starve_q;
        we_d      = we_q;
        cancel_d  = cancel_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        if_rvalid = 1'b0;
        dm_rvalid = 1'b0;

        case (state_q)
            IDLE: begin
                cancel_d = 1'b0;
                if (!bus.if_req) begin
                    starve_d = '0;
                end
                // DM wins unless IF has already watched STARVE_MAX DM grants go by
                if (bus.dm_req && (!bus.if_req || (starve_q < SMAX))) begin
                    state_d = ISSUE;
                    owner_d = OWN_DM;
                    we_d    = bus.dm_we;
                    addr_d  = bus.dm_addr;
                    wdata_d = bus.dm_wdata;
                    if (bus.if_req && (starve_q != SMAX)) begin
                        starve_d = starve_q + 4'd1;
                    end
                end else if (bus.if_req) begin
                    state_d  = ISSUE;
                    owner_d  = OWN_IF;
                    we_d     = 1'b0;
                    addr_d   = bus.if_addr;
                    wdata_d  = '0;
                    starve_d = '0;
                end
            end
            ISSUE: begin
                mem_en  = 1'b1;
                mem_we  = we_q;
                lat_d   = 4'd1;
                state_d = WAIT;
                if ((owner_q == OWN_IF) && bus.if_flush) begin
                    cancel_d = 1'b1;
                end
            end
            WAIT: begin
                lat_d = lat_q + 4'd1;
                if ((owner_q == OWN_IF) && bus.if_flush) begin
                    cancel_d = 1'b1;
                end
                if (lat_q == LAT) begin
                    // a flush arriving in the response cycle itself also kills delivery
                    dm_rvalid = (owner_q == OWN_DM);
                    if_rvalid = (owner_q == OWN_IF) && !(cancel_q || bus.if_flush);
                    state_d   = IDLE;
                    owner_d   = OWN_NONE;
                    cancel_d  = 1'b0;
                    lat_d     = '0;
                end
            end
            default: begin
                state_d = IDLE;
                owner_d = OWN_NONE;
            end
        endcase
    end

    assign bus.mem_en    = mem_en;
    assign bus.mem_we    = mem_we;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.if_rvalid = if_rvalid;
    assign bus.dm_rvalid = dm_rvalid;
    assign bus.if_rdata  = bus.mem_rdata[31:0];
    assign bus.dm_rdata  = bus.mem_rdata;
    assign bus.stall_if  = bus.if_req & ~if_rvalid;
    assign bus.stall_mem = bus.dm_req & ~dm_rvalid;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(64), .DATA_W(64)) b   ();
    mem_port_arbiter_if #(.ADDR_W(64), .DATA_W(64)) b1  ();
    mem_port_arbiter_if #(.ADDR_W(64), .DATA_W(64)) b15 ();

    mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(2), .STARVE_MAX(4))
        u0 (.clk(clk), .reset(rst_n), .bus(b));
    mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(1), .STARVE_MAX(4))
        u1 (.clk(clk), .reset(rst_n), .bus(b1));
    mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(15), .STARVE_MAX(4))
        u15 (.clk(clk), .reset(rst_n), .bus(b15));

    function automatic logic [63:0] mem_val(input logic [63:0] a);
        return {a[31:0] ^ 32'hA5A5_0000, ~a[31:0]};
    endfunction

    // fixed-latency memory models: data valid exactly MEM_LAT cycles after mem_en
    logic [63:0] p0 [16];
    logic [63:0] p1 [16];
    logic [63:0] p15[16];
    always @(posedge clk) begin
        p0[0]  <= b.mem_en   ? mem_val(b.mem_addr)   : 64'h0;
        p1[0]  <= b1.mem_en  ? mem_val(b1.mem_addr)  : 64'h0;
        p15[0] <= b15.mem_en ? mem_val(b15.mem_addr) : 64'h0;
        for (int k = 1; k < 16; k++) begin
            p0[k]  <= p0[k-1];
            p1[k]  <= p1[k-1];
            p15[k] <= p15[k-1];
        end
    end
    assign b.mem_rdata   = p0[1];
    assign b1.mem_rdata  = p1[0];
    assign b15.mem_rdata = p15[14];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        checks++; if (b.mem_en !== 1'b0 || b.mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_en got en=%0b we=%0b exp 0/0", b.mem_en, b.mem_we); end
        checks++; if (b.mem_addr !== 64'h0 || b.mem_wdata !== 64'h0) begin errors++; $display("FAIL reset_mem_addr got %h/%h exp 0/0", b.mem_addr, b.mem_wdata); end
        checks++; if (b.if_rvalid !== 1'b0 || b.dm_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got if=%0b dm=%0b exp 0/0", b.if_rvalid, b.dm_rvalid); end
        rst_n = 1'b1;
        step();
        step();
        checks++; if (b.mem_en !== 1'b0 || b.stall_if !== 1'b0 || b.stall_mem !== 1'b0) begin errors++; $display("FAIL reset_idle got en=%0b sif=%0b smem=%0b exp 0", b.mem_en, b.stall_if, b.stall_mem); end
    endtask

    task automatic test_if_only();
        b.if_req = 1'b1; b.if_addr = 64'h40;
        #1;
        checks++; if (b.stall_if !== 1'b1) begin errors++; $display("FAIL t1_stall_c0 got %0b exp 1", b.stall_if); end
        step();
        checks++; if (b.mem_en !== 1'b1 || b.mem_we !== 1'b0 || b.mem_addr !== 64'h40) begin errors++; $display("FAIL t1_issue got en=%0b we=%0b addr=%h exp 1/0/40", b.mem_en, b.mem_we, b.mem_addr); end
        step();
        checks++; if (b.mem_en !== 1'b0 || b.if_rvalid !== 1'b0 || b.stall_if !== 1'b1) begin errors++; $display("FAIL t1_c2 got en=%0b rv=%0b stall=%0b exp 0/0/1", b.mem_en, b.if_rvalid, b.stall_if); end
        step();
        checks++; if (b.if_rvalid !== 1'b1 || b.stall_if !== 1'b0) begin errors++; $display("FAIL t1_rvalid got rv=%0b stall=%0b exp 1/0", b.if_rvalid, b.stall_if); end
        checks++; if (b.if_rdata !== 32'hFFFF_FFBF) begin errors++; $display("FAIL t1_rdata got %h exp ffffffbf", b.if_rdata); end
        b.if_req = 1'b0;
        step();
    endtask

    task automatic test_priority();
        b.if_req = 1'b1; b.if_addr = 64'h80;
        b.dm_req = 1'b1; b.dm_we = 1'b1; b.dm_addr = 64'h100; b.dm_wdata = 64'hDEAD;
        step();
        checks++; if (b.mem_en !== 1'b1 || b.mem_we !== 1'b1 || b.mem_addr !== 64'h100 || b.mem_wdata !== 64'hDEAD) begin errors++; $display("FAIL t2_dm_issue got en=%0b we=%0b addr=%h wd=%h exp 1/1/100/dead", b.mem_en, b.mem_we, b.mem_addr, b.mem_wdata); end
        checks++; if (b.stall_if !== 1'b1 || b.stall_mem !== 1'b1) begin errors++; $display("FAIL t2_stalls got sif=%0b smem=%0b exp 1/1", b.stall_if, b.stall_mem); end
        step();
        step();
        checks++; if (b.dm_rvalid !== 1'b1 || b.if_rvalid !== 1'b0 || b.stall_mem !== 1'b0) begin errors++; $display("FAIL t2_dm_rvalid got dm=%0b if=%0b smem=%0b exp 1/0/0", b.dm_rvalid, b.if_rvalid, b.stall_mem); end
        b.dm_req = 1'b0; b.dm_we = 1'b0;
        step();
        checks++; if (b.mem_en !== 1'b0) begin errors++; $display("FAIL t2_gap_c4 got en=%0b exp 0", b.mem_en); end
        step();
        checks++; if (b.mem_en !== 1'b1 || b.mem_we !== 1'b0 || b.mem_addr !== 64'h80) begin errors++; $display("FAIL t2_if_issue got en=%0b we=%0b addr=%h exp 1/0/80", b.mem_en, b.mem_we, b.mem_addr); end
        step();
        step();
        checks++; if (b.if_rvalid !== 1'b1 || b.if_rdata !== 32'hFFFF_FF7F) begin errors++; $display("FAIL t2_if_rvalid got rv=%0b data=%h exp 1/ffffff7f", b.if_rvalid, b.if_rdata); end
        b.if_req = 1'b0;
        step();
    endtask

    task automatic test_starvation();
        logic [63:0] exp_a [6];
        int dmn;
        exp_a[0] = 64'h1000; exp_a[1] = 64'h1008; exp_a[2] = 64'h1010;
        exp_a[3] = 64'h1018; exp_a[4] = 64'h200;  exp_a[5] = 64'h1020;
        dmn = 0;
        b.dm_req = 1'b1; b.dm_we = 1'b0; b.dm_addr = 64'h1000;
        b.if_req = 1'b1; b.if_addr = 64'h200;
        for (int g = 0; g < 6; g++) begin
            for (int n = 0; n < 12 && b.mem_en !== 1'b1; n++) step();
            checks++; if (b.mem_en !== 1'b1 || b.mem_addr !== exp_a[g]) begin errors++; $display("FAIL t3_grant%0d got en=%0b addr=%h exp 1/%h", g, b.mem_en, b.mem_addr, exp_a[g]); end
            if (g == 1) begin
                checks++; if (b.stall_if !== 1'b1) begin errors++; $display("FAIL t3_loser_stall got %0b exp 1", b.stall_if); end
            end
            if (g == 3) begin
                checks++; if (u0.starve_q !== 4'd4) begin errors++; $display("FAIL t3_starve_sat got %0d exp 4", u0.starve_q); end
            end
            if (g == 4) begin
                checks++; if (u0.starve_q !== 4'd0) begin errors++; $display("FAIL t3_starve_clr got %0d exp 0", u0.starve_q); end
            end
            step();
            for (int n = 0; n < 12 && b.dm_rvalid !== 1'b1 && b.if_rvalid !== 1'b1; n++) step();
            checks++; if (((g == 4) ? b.if_rvalid : b.dm_rvalid) !== 1'b1) begin errors++; $display("FAIL t3_rvalid%0d got if=%0b dm=%0b exp owner=%s", g, b.if_rvalid, b.dm_rvalid, (g == 4) ? "IF" : "DM"); end
            if (b.dm_rvalid === 1'b1) begin
                dmn++;
                b.dm_addr = 64'h1000 + 64'(8 * dmn);
                if (dmn == 5) b.dm_req = 1'b0;
            end
            if (b.if_rvalid === 1'b1) b.if_req = 1'b0;
        end
        b.dm_req = 1'b0; b.if_req = 1'b0;
        step();
    endtask

    task automatic test_flush();
        b.if_req = 1'b1; b.if_addr = 64'h300;
        step();
        checks++; if (b.mem_en !== 1'b1 || b.mem_addr !== 64'h300) begin errors++; $display("FAIL t4_issue got en=%0b addr=%h exp 1/300", b.mem_en, b.mem_addr); end
        step();
        b.if_flush = 1'b1;
        step();
        b.if_flush = 1'b0;
        #1;
        checks++; if (b.if_rvalid !== 1'b0 || b.stall_if !== 1'b1) begin errors++; $display("FAIL t4_suppress got rv=%0b stall=%0b exp 0/1", b.if_rvalid, b.stall_if); end
        b.if_addr = 64'h340;
        step();
        checks++; if (b.mem_en !== 1'b0) begin errors++; $display("FAIL t4_idle got en=%0b exp 0", b.mem_en); end
        b.if_flush = 1'b1;
        step();
        b.if_flush = 1'b0;
        checks++; if (b.mem_en !== 1'b1 || b.mem_addr !== 64'h340) begin errors++; $display("FAIL t4_reissue got en=%0b addr=%h exp 1/340", b.mem_en, b.mem_addr); end
        step();
        step();
        checks++; if (b.if_rvalid !== 1'b1 || b.if_rdata !== 32'hFFFF_FCBF) begin errors++; $display("FAIL t4_after got rv=%0b data=%h exp 1/fffffcbf", b.if_rvalid, b.if_rdata); end
        b.if_req = 1'b0;
        step();
    endtask

    task automatic test_async_reset();
        int stray;
        b.dm_req = 1'b1; b.dm_we = 1'b0; b.dm_addr = 64'h500; b.dm_wdata = 64'hBEEF;
        step();
        checks++; if (b.mem_en !== 1'b1 || b.mem_addr !== 64'h500 || b.mem_wdata !== 64'hBEEF) begin errors++; $display("FAIL t5_issue got en=%0b addr=%h wd=%h exp 1/500/beef", b.mem_en, b.mem_addr, b.mem_wdata); end
        step();
        rst_n = 1'b0;
        #1;
        checks++; if (b.mem_addr !== 64'h0 || b.mem_wdata !== 64'h0 || b.mem_en !== 1'b0 || b.mem_we !== 1'b0) begin errors++; $display("FAIL t5_async got addr=%h wd=%h en=%0b we=%0b exp 0", b.mem_addr, b.mem_wdata, b.mem_en, b.mem_we); end
        b.dm_req = 1'b0;
        step();
        rst_n = 1'b1;
        stray = 0;
        for (int n = 0; n < 6; n++) begin
            step();
            if (b.dm_rvalid === 1'b1 || b.if_rvalid === 1'b1 || b.mem_en === 1'b1) stray++;
        end
        checks++; if (stray !== 0) begin errors++; $display("FAIL t5_stale got %0d pulses exp 0", stray); end
        b.if_req = 1'b1; b.if_addr = 64'h600;
        step();
        checks++; if (b.mem_en !== 1'b1 || b.mem_addr !== 64'h600) begin errors++; $display("FAIL t5_resume got en=%0b addr=%h exp 1/600", b.mem_en, b.mem_addr); end
        step();
        step();
        checks++; if (b.if_rvalid !== 1'b1 || b.if_rdata !== 32'hFFFF_F9FF) begin errors++; $display("FAIL t5_resume_rv got rv=%0b data=%h exp 1/fffff9ff", b.if_rvalid, b.if_rdata); end
        b.if_req = 1'b0;
        step();
    endtask

    task automatic test_lat_sweep();
        int en1, rv1, en15, rv15, np1, np15;
        logic [31:0] d1, d15;
        en1 = -1; rv1 = -1; en15 = -1; rv15 = -1; np1 = 0; np15 = 0;
        d1 = 32'h0; d15 = 32'h0;
        b1.if_req = 1'b1;  b1.if_addr = 64'h700;
        b15.if_req = 1'b1; b15.if_addr = 64'h700;
        for (int c = 0; c < 24; c++) begin
            if (b1.mem_en === 1'b1 && en1 < 0) en1 = c;
            if (b15.mem_en === 1'b1 && en15 < 0) en15 = c;
            if (b1.if_rvalid === 1'b1) begin np1++; if (rv1 < 0) begin rv1 = c; d1 = b1.if_rdata; end b1.if_req = 1'b0; end
            if (b15.if_rvalid === 1'b1) begin np15++; if (rv15 < 0) begin rv15 = c; d15 = b15.if_rdata; end b15.if_req = 1'b0; end
            step();
        end
        checks++; if (en1 !== 1 || rv1 !== 2 || np1 !== 1) begin errors++; $display("FAIL t6_lat1 got en@%0d rv@%0d n=%0d exp 1/2/1", en1, rv1, np1); end
        checks++; if (en15 !== 1 || rv15 !== 16 || np15 !== 1) begin errors++; $display("FAIL t6_lat15 got en@%0d rv@%0d n=%0d exp 1/16/1", en15, rv15, np15); end
        checks++; if (d1 !== 32'hFFFF_F8FF || d15 !== 32'hFFFF_F8FF) begin errors++; $display("FAIL t6_rdata got %h/%h exp fffff8ff", d1, d15); end
    endtask

    initial begin
        b.if_req = 1'b0; b.if_addr = '0; b.if_flush = 1'b0;
        b.dm_req = 1'b0; b.dm_we = 1'b0; b.dm_addr = '0; b.dm_wdata = '0;
        b1.if_req = 1'b0; b1.if_addr = '0; b1.if_flush = 1'b0;
        b1.dm_req = 1'b0; b1.dm_we = 1'b0; b1.dm_addr = '0; b1.dm_wdata = '0;
        b15.if_req = 1'b0; b15.if_addr = '0; b15.if_flush = 1'b0;
        b15.dm_req = 1'b0; b15.dm_we = 1'b0; b15.dm_addr = '0; b15.dm_wdata = '0;
        rst_n = 1'b0;
        test_reset();
        test_if_only();
        test_priority();
        test_starvation();
        test_flush();
        test_async_reset();
        test_lat_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
